id_ex_stage: RTL

Decode/operand-select stage and ID/EX pipeline register that sits directly upstream of the 32-bit ALU in the pipelined CPU.
- Decodes the instruction into the ALU's 3-bit command: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
- Resolves operands with EX/MEM and MEM/WB forwarding and selects register or immediate for operand B.
- Registers everything for the EX stage, with stall and flush control.

---
 rtl/id_ex_stage.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// Decode / operand-select stage feeding the 32-bit ALU, with the ID/EX
// pipeline register, stall/flush control and a saturating illegal counter.
module id_ex_stage #(
  parameter bit         FWD_EN     = 1'b1,
  parameter logic [5:0] NAND_FUNCT = 6'h28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [2:0]  alu_command,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [4:0]  dest_reg,
  output logic        reg_write,
  output logic        illegal,
  output logic [15:0] illegal_count
);

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        unused_shamt;

  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign funct        = instr[5:0];
  assign imm          = instr[15:0];
  assign unused_shamt = ^instr[10:6];

  // Decode results
  logic        dec_legal;
  logic [2:0]  dec_cmd;
  logic        dec_use_imm;
  logic        dec_sext;

  always_comb begin
    dec_legal   = 1'b0;
    dec_cmd     = CMD_ADD;
    dec_use_imm = 1'b0;
    dec_sext    = 1'b0;
    if (opcode == OP_RTYPE) begin
      dec_legal = 1'b1;
      if (funct == NAND_FUNCT) begin
        dec_cmd = CMD_NAND;
      end else begin
        case (funct)
          6'h20, 6'h21: dec_cmd = CMD_ADD;
          6'h22, 6'h23: dec_cmd = CMD_SUB;
          6'h24:        dec_cmd = CMD_AND;
          6'h25:        dec_cmd = CMD_OR;
          6'h26:        dec_cmd = CMD_XOR;
          6'h27:        dec_cmd = CMD_NOR;
          6'h2A:        dec_cmd = CMD_SLT;
          default: begin
            dec_legal = 1'b0;
            dec_cmd   = CMD_ADD;
          end
        endcase
      end
    end else begin
      dec_use_imm = 1'b1;
      dec_legal   = 1'b1;
      case (opcode)
        OP_ADDI: begin dec_cmd = CMD_ADD; dec_sext = 1'b1; end
        OP_SLTI: begin dec_cmd = CMD_SLT; dec_sext = 1'b1; end
        OP_ANDI: dec_cmd = CMD_AND;
        OP_ORI:  dec_cmd = CMD_OR;
        OP_XORI: dec_cmd = CMD_XOR;
        default: begin
          dec_legal   = 1'b0;
          dec_use_imm = 1'b0;
          dec_cmd     = CMD_ADD;
        end
      endcase
    end
  end

  // Forwarding: EX/MEM beats MEM/WB; $0 is never forwarded.
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  always_comb begin
    fwd_rs = rs_data;
    if (FWD_EN && (rs != 5'd0)) begin
      if (exmem_regwrite && (exmem_rd == rs)) begin
        fwd_rs = exmem_result;
      end else if (memwb_regwrite && (memwb_rd == rs)) begin
        fwd_rs = memwb_result;
      end
    end
  end

  always_comb begin
    fwd_rt = rt_data;
    if (FWD_EN && (rt != 5'd0)) begin
      if (exmem_regwrite && (exmem_rd == rt)) begin
        fwd_rt = exmem_result;
      end else if (memwb_regwrite && (memwb_rd == rt)) begin
        fwd_rt = memwb_result;
      end
    end
  end

  logic [31:0] imm_ext;
  logic [4:0]  dec_dest;

  assign imm_ext  = dec_sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  // Only R-type writes rd; everything else (including illegal opcodes) names rt.
  assign dec_dest = (opcode == OP_RTYPE) ? rd : rt;

  // ID/EX register
  logic        ex_valid_q,      ex_valid_d;
  logic [2:0]  alu_command_q,   alu_command_d;
  logic [31:0] operand_a_q,     operand_a_d;
  logic [31:0] operand_b_q,     operand_b_d;
  logic [4:0]  dest_reg_q,      dest_reg_d;
  logic        reg_write_q,     reg_write_d;
  logic        illegal_q,       illegal_d;
  logic [15:0] illegal_count_q, illegal_count_d;

  always_comb begin
    ex_valid_d      = ex_valid_q;
    alu_command_d   = alu_command_q;
    operand_a_d     = operand_a_q;
    operand_b_d     = operand_b_q;
    dest_reg_d      = dest_reg_q;
    reg_write_d     = reg_write_q;
    illegal_d       = illegal_q;
    illegal_count_d = illegal_count_q;
    if (flush) begin
      ex_valid_d    = 1'b0;
      alu_command_d = CMD_ADD;
      operand_a_d   = 32'h0;
      operand_b_d   = 32'h0;
      dest_reg_d    = 5'd0;
      reg_write_d   = 1'b0;
      illegal_d     = 1'b0;
    end else if (!stall) begin
      ex_valid_d    = in_valid;
      alu_command_d = dec_cmd;
      operand_a_d   = fwd_rs;
      operand_b_d   = dec_use_imm ? imm_ext : fwd_rt;
      dest_reg_d    = dec_dest;
      reg_write_d   = in_valid && dec_legal && (dec_dest != 5'd0);
      illegal_d     = in_valid && !dec_legal;
      if (in_valid && !dec_legal && (illegal_count_q != 16'hFFFF)) begin
        illegal_count_d = illegal_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      alu_command_q   <= 3'd0;
      operand_a_q     <= 32'h0;
      operand_b_q     <= 32'h0;
      dest_reg_q      <= 5'd0;
      reg_write_q     <= 1'b0;
      illegal_q       <= 1'b0;
      illegal_count_q <= 16'h0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      alu_command_q   <= alu_command_d;
      operand_a_q     <= operand_a_d;
      operand_b_q     <= operand_b_d;
      dest_reg_q      <= dest_reg_d;
      reg_write_q     <= reg_write_d;
      illegal_q       <= illegal_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign alu_command   = alu_command_q;
  assign operand_a     = operand_a_q;
  assign operand_b     = operand_b_q;
  assign dest_reg      = dest_reg_q;
  assign reg_write     = reg_write_q;
  assign illegal       = illegal_q;
  assign illegal_count = illegal_count_q;

endmodule
